// File: rtl/display_page_sched_pkg.sv
// Shared constants and state encoding for the display page scheduler.
package display_page_sched_pkg;

    localparam int NUM_PAGES = 8;

    typedef enum logic {
        ST_ROTATE = 1'b0,
        ST_ALERT  = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/display_page_sched_page_search.sv
// Circular search for the nearest set mask bit strictly after (dir=1) or
// before (dir=0) cur; wraps around and lands on cur itself if only cur is set.
module display_page_sched_page_search
    import display_page_sched_pkg::*;
(
    input  logic [2:0] cur,
    input  logic [7:0] mask,
    input  logic       dir,
    output logic [2:0] idx
);

    logic [2:0]           w_cand [NUM_PAGES];
    logic [NUM_PAGES-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_cand
            // Distance gi+1 from cur; the 3-bit wrap gives the circular order.
            assign w_cand[gi] = dir ? (cur + 3'(gi + 1)) : (cur - 3'(gi + 1));
            assign w_hit[gi]  = mask[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        idx = cur;
        for (int k = NUM_PAGES - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/display_page_sched.sv
// Display page sequencer: auto-rotation, manual next/prev and preemptive
// alert pages with a fixed hold, all feeding the 7-segment content mux select.
module display_page_sched
    import display_page_sched_pkg::*;
#(
    parameter int DWELL_TICKS = 3000,
    parameter int HOLD_TICKS  = 2000,
    parameter int CW          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       auto_en,
    input  logic [7:0] page_en,
    input  logic       next,
    input  logic       prev,
    input  logic [7:0] alert_req,
    output logic [3:0] sel,
    output logic       page_changed,
    output logic [7:0] alert_ack,
    output logic       alert_active
);

    state_t        r_state;
    logic [2:0]    r_sel;
    logic [2:0]    r_home;
    logic [7:0]    r_pending;
    logic [CW-1:0] r_counter;
    logic          r_page_changed;
    logic [7:0]    r_alert_ack;
    logic          r_alert_active;

    state_t        w_state_next;
    logic [2:0]    w_sel_next;
    logic [2:0]    w_home_next;
    logic [7:0]    w_pending_next;
    logic [CW-1:0] w_counter_next;
    logic [7:0]    w_ack_next;

    logic [7:0]    w_em;
    logic [7:0]    w_pend_all;
    logic [7:0]    w_pend_onehot;
    logic [2:0]    w_next_idx;
    logic [2:0]    w_prev_idx;
    logic [2:0]    w_pend_idx;
    logic          w_dwell_last;
    logic          w_hold_last;

    // An empty mask falls back to page 0 so the rotation always has a target.
    assign w_em          = (page_en == 8'h00) ? 8'h01 : page_en;
    assign w_pend_all    = r_pending | alert_req;
    assign w_pend_onehot = 8'h01 << w_pend_idx;
    assign w_dwell_last  = (r_counter == CW'(DWELL_TICKS - 1));
    assign w_hold_last   = (r_counter == CW'(HOLD_TICKS - 1));

    display_page_sched_page_search u_search_next (
        .cur  (r_sel),
        .mask (w_em),
        .dir  (DIR_UP),
        .idx  (w_next_idx)
    );

    display_page_sched_page_search u_search_prev (
        .cur  (r_sel),
        .mask (w_em),
        .dir  (DIR_DOWN),
        .idx  (w_prev_idx)
    );

    // Searching upward from 7 yields the lowest set pending bit.
    display_page_sched_page_search u_search_pend (
        .cur  (3'd7),
        .mask (w_pend_all),
        .dir  (DIR_UP),
        .idx  (w_pend_idx)
    );

    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_home_next    = r_home;
        w_pending_next = w_pend_all;
        w_counter_next = r_counter;
        w_ack_next     = 8'h00;

        case (r_state)
            ST_ROTATE: begin
                if (w_pend_all != 8'h00) begin
                    w_state_next   = ST_ALERT;
                    w_home_next    = r_sel;
                    w_sel_next     = w_pend_idx;
                    w_pending_next = w_pend_all & ~w_pend_onehot;
                    w_ack_next     = w_pend_onehot;
                    w_counter_next = '0;
                end else if (next ^ prev) begin
                    w_sel_next     = next ? w_next_idx : w_prev_idx;
                    w_counter_next = '0;
                end else if (!auto_en) begin
                    w_counter_next = '0;
                end else if (tick) begin
                    if (w_dwell_last) begin
                        w_sel_next     = w_next_idx;
                        w_counter_next = '0;
                    end else begin
                        w_counter_next = r_counter + 1'b1;
                    end
                end
            end
            ST_ALERT: begin
                if (tick) begin
                    if (!w_hold_last) begin
                        w_counter_next = r_counter + 1'b1;
                    end else if (w_pend_all != 8'h00) begin
                        w_sel_next     = w_pend_idx;
                        w_pending_next = w_pend_all & ~w_pend_onehot;
                        w_ack_next     = w_pend_onehot;
                        w_counter_next = '0;
                    end else begin
                        w_state_next   = ST_ROTATE;
                        w_sel_next     = r_home;
                        w_counter_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_ROTATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ROTATE;
            r_sel          <= 3'd0;
            r_home         <= 3'd0;
            r_pending      <= 8'h00;
            r_counter      <= '0;
            r_page_changed <= 1'b0;
            r_alert_ack    <= 8'h00;
            r_alert_active <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_sel          <= w_sel_next;
            r_home         <= w_home_next;
            r_pending      <= w_pending_next;
            r_counter      <= w_counter_next;
            r_page_changed <= (w_sel_next != r_sel);
            r_alert_ack    <= w_ack_next;
            r_alert_active <= (w_state_next == ST_ALERT);
        end
    end

    assign sel          = {1'b0, r_sel};
    assign page_changed = r_page_changed;
    assign alert_ack    = r_alert_ack;
    assign alert_active = r_alert_active;

endmodule

// File: tb/tb_display_page_sched.sv
// Directed bench for display_page_sched with short dwell/hold times.
module tb_display_page_sched;

    localparam int DWELL = 3;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       auto_en;
    logic [7:0] page_en;
    logic       next;
    logic       prev;
    logic [7:0] alert_req;
    logic [3:0] sel;
    logic       page_changed;
    logic [7:0] alert_ack;
    logic       alert_active;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       nxt;
        logic       prv;
        logic       tck;
        logic       aen;
        logic [7:0] pe;
        logic [7:0] areq;
        logic [3:0] e_sel;
        logic       e_pc;
        logic [7:0] e_ack;
        logic       e_act;
    } vec_t;

    vec_t vecs[$];

    display_page_sched #(
        .DWELL_TICKS (DWELL),
        .HOLD_TICKS  (HOLD),
        .CW          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .auto_en      (auto_en),
        .page_en      (page_en),
        .next         (next),
        .prev         (prev),
        .alert_req    (alert_req),
        .sel          (sel),
        .page_changed (page_changed),
        .alert_ack    (alert_ack),
        .alert_active (alert_active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic nx, logic pv, logic tk, logic ae, logic [7:0] pe,
                                logic [7:0] ar, logic [3:0] s, logic pc, logic [7:0] ak,
                                logic act);
        vec_t v;
        v.nxt = nx; v.prv = pv; v.tck = tk; v.aen = ae; v.pe = pe; v.areq = ar;
        v.e_sel = s; v.e_pc = pc; v.e_ack = ak; v.e_act = act;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    endtask

    task automatic chk_outs(input string nm, input int idx, input logic [3:0] s,
                            input logic pc, input logic [7:0] ak, input logic act);
        $display("%s[%0d]: sel=%0d pc=%0b ack=%02h act=%0b (exp %0d %0b %02h %0b)",
                 nm, idx, sel, page_changed, alert_ack, alert_active, s, pc, ak, act);
        chk({nm, ".sel"}, idx, 32'(sel), 32'(s));
        chk({nm, ".page_changed"}, idx, 32'(page_changed), 32'(pc));
        chk({nm, ".alert_ack"}, idx, 32'(alert_ack), 32'(ak));
        chk({nm, ".alert_active"}, idx, 32'(alert_active), 32'(act));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic nx, input logic pv, input logic tk, input logic ae,
                        input logic [7:0] pe, input logic [7:0] ar);
        next = nx; prev = pv; tick = tk; auto_en = ae; page_en = pe; alert_req = ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; tick = 0; auto_en = 0; page_en = 8'hFF;
        next = 0; prev = 0; alert_req = 8'h00;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 8'hFF, 8'h00);
        chk_outs("reset", 0, 4'd0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        // Auto-rotation: one step every DWELL ticks, wrapping 7 -> 0.
        for (int c = 1; c <= 8 * DWELL; c++) begin
            step(0, 0, 1, 1, 8'hFF, 8'h00);
            chk_outs("rotate", c, 4'((c / DWELL) % 8), (c % DWELL) == 0, 8'h00, 1'b0);
        end

        //               nx pv tk ae  pe      areq   sel pc ack    act
        vecs.push_back(mk(1, 0, 0, 0, 8'hA4, 8'h00, 2, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA4, 8'h00, 5, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA4, 8'h00, 7, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA4, 8'h00, 2, 1, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'hA4, 8'h00, 7, 1, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'hA4, 8'h00, 7, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'hA4, 8'h00, 7, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h10, 8'h00, 4, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'hA4, 8'h00, 5, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h04, 8'h00, 5, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h04, 8'h00, 2, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h00, 2, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'hFF, 8'h00, 3, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h42, 1, 1, 8'h02, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 6, 1, 8'h40, 1));
        vecs.push_back(mk(0, 1, 1, 0, 8'hFF, 8'h00, 6, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 6, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 6, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 8'h00, 3, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'hFF, 8'h00, 3, 0, 8'h00, 0));

        foreach (vecs[i]) begin
            step(vecs[i].nxt, vecs[i].prv, vecs[i].tck, vecs[i].aen, vecs[i].pe, vecs[i].areq);
            chk_outs("vec", i, vecs[i].e_sel, vecs[i].e_pc, vecs[i].e_ack, vecs[i].e_act);
        end

        // Alert coincident with next and a dwell-expiry tick: alert wins.
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        chk_outs("coinc_pre", 0, 4'd3, 1'b0, 8'h00, 1'b0);
        step(1, 0, 1, 1, 8'hFF, 8'h20);
        chk_outs("coinc_entry", 0, 4'd5, 1'b1, 8'h20, 1'b1);
        for (int k = 1; k < HOLD; k++) begin
            step(0, 0, 1, 1, 8'hFF, 8'h00);
            chk_outs("coinc_hold", k, 4'd5, 1'b0, 8'h00, 1'b1);
        end
        step(0, 0, 1, 1, 8'hFF, 8'h00);
        chk_outs("coinc_return", 0, 4'd3, 1'b1, 8'h00, 1'b0);
        step(0, 0, 0, 0, 8'hFF, 8'h00);
        chk_outs("coinc_idle", 0, 4'd3, 1'b0, 8'h00, 1'b0);

        // Re-request of the page already on alert is served again after the hold.
        step(0, 0, 0, 0, 8'hFF, 8'h04);
        chk_outs("rereq_entry", 0, 4'd2, 1'b1, 8'h04, 1'b1);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        step(0, 0, 1, 0, 8'hFF, 8'h04);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        chk_outs("rereq_hold", 0, 4'd2, 1'b0, 8'h00, 1'b1);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        chk_outs("rereq_again", 0, 4'd2, 1'b0, 8'h04, 1'b1);
        for (int k = 1; k < HOLD; k++) step(0, 0, 1, 0, 8'hFF, 8'h00);
        chk_outs("rereq_hold2", 0, 4'd2, 1'b0, 8'h00, 1'b1);
        step(0, 0, 1, 0, 8'hFF, 8'h00);
        chk_outs("rereq_return", 0, 4'd3, 1'b1, 8'h00, 1'b0);

        // Reset during an alert with a request still pending.
        step(0, 0, 0, 0, 8'hFF, 8'h06);
        chk_outs("rst_entry", 0, 4'd1, 1'b1, 8'h02, 1'b1);
        reset = 1'b1;
        step(0, 0, 0, 0, 8'hFF, 8'h00);
        chk_outs("rst_mid", 0, 4'd0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 2 * HOLD; k++) begin
            step(0, 0, 1, 0, 8'hFF, 8'h00);
            chk_outs("rst_after", k, 4'd0, 1'b0, 8'h00, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
